// File: rtl/axi_phase_discriminator_pkg.sv
// Shared constants for the FM phase discriminator slice.
// No logic here: widths, decimation limit and sc16 packing helpers.
// Not applicable: no handshake in a package.
package axi_phase_discriminator_pkg;

    localparam int WIDTH          = 16;
    localparam int MAX_LOG2_DECIM = 8;
    localparam int ACC_WIDTH      = WIDTH + MAX_LOG2_DECIM;

    // sc16 words carry the real part in the upper half; the lower half is zero.
    localparam logic [WIDTH-1:0] SC16_LOW_ZERO = '0;

    // Requests above the supported range collapse to the largest decimation.
    function automatic logic [3:0] clamp_log2(input logic [3:0] req);
        if (req > 4'(MAX_LOG2_DECIM)) begin
            return 4'(MAX_LOG2_DECIM);
        end
        return req;
    endfunction

endpackage

// File: rtl/axi_phase_discriminator_if.sv
// AXI-stream style sc16 bus between the discriminator and its neighbours.
// Wires only, zero latency.
// tready is driven by the sink; master holds data while tvalid & ~tready.
interface axi_phase_discriminator_if
    import axi_phase_discriminator_pkg::*;
    ;

    logic [2*WIDTH-1:0] tdata;
    logic               tlast;
    logic               tvalid;
    logic               tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);

endinterface

// File: rtl/axi_phase_discriminator_phase_diff_wrap.sv
// Modular phase differencer: d = phase - prev_phase (wraps mod 2^WIDTH), d = 0 on first sample.
// Zero latency on the data path; prev_phase/prev_valid are registered state.
// Ready passes straight through; clear drops the beat and forgets prev_phase.
module axi_phase_discriminator_phase_diff_wrap
    import axi_phase_discriminator_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] phase_dat,
    input  logic             phase_vld,
    input  logic             phase_last,
    output logic             phase_rdy,
    output logic [WIDTH-1:0] diff_dat,
    output logic             diff_vld,
    output logic             diff_last,
    input  logic             diff_rdy
);

    logic [WIDTH-1:0] prev_phase_q, prev_phase_d;
    logic             prev_valid_q, prev_valid_d;
    logic             accept;

    assign phase_rdy = diff_rdy;
    assign diff_vld  = phase_vld & ~clear;
    assign diff_last = phase_last;
    assign accept    = diff_vld & diff_rdy;
    // Natural two's-complement wrap performs the +/-pi unwrap.
    assign diff_dat  = prev_valid_q ? (phase_dat - prev_phase_q) : '0;

    // Remember the last accepted phase; persists across packets until reset/clear.
    always_comb begin
        prev_phase_d = prev_phase_q;
        prev_valid_d = prev_valid_q;
        if (clear) begin
            prev_phase_d = '0;
            prev_valid_d = 1'b0;
        end else if (accept) begin
            prev_phase_d = phase_dat;
            prev_valid_d = 1'b1;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_phase_q <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_phase_q <= prev_phase_d;
            prev_valid_q <= prev_valid_d;
        end
    end

endmodule

// File: rtl/axi_phase_discriminator.sv
// FM discriminator: phase differences integrated and dumped every 2^k beats (or on tlast), rounded >>> k.
// One cycle from the dumping input beat to o_tvalid; 1 word/cycle at k=0.
// i_tready = ~o_tvalid | o_tready; output register holds while stalled.
module axi_phase_discriminator
    import axi_phase_discriminator_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [3:0]                  log2_decim,
    axi_phase_discriminator_if.slave    s_in,
    axi_phase_discriminator_if.master   m_out
);

    localparam int CNT_W = MAX_LOG2_DECIM;

    logic [ACC_WIDTH-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [3:0]                k_q, k_d;
    logic                      o_vld_q, o_vld_d;
    logic [WIDTH-1:0]          o_dat_q, o_dat_d;
    logic                      o_last_q, o_last_d;

    logic                      in_rdy;
    logic [WIDTH-1:0]          diff_dat;
    logic                      diff_vld;
    logic                      diff_last;
    logic                      beat;
    logic [3:0]                k_cur;
    logic [CNT_W:0]            win_last_cnt;
    logic                      window_end;
    logic [ACC_WIDTH-1:0]      acc_sum;
    logic [ACC_WIDTH:0]        half;
    logic signed [ACC_WIDTH:0] rnd_sum;
    logic signed [ACC_WIDTH:0] shifted;
    logic [WIDTH-1:0]          freq;

    assign in_rdy        = ~o_vld_q | m_out.tready;
    assign s_in.tready   = in_rdy;
    assign m_out.tvalid  = o_vld_q;
    assign m_out.tlast   = o_last_q;
    assign m_out.tdata   = {o_dat_q, SC16_LOW_ZERO};

    axi_phase_discriminator_phase_diff_wrap u_diff (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .phase_dat  (s_in.tdata[2*WIDTH-1:WIDTH]),
        .phase_vld  (s_in.tvalid),
        .phase_last (s_in.tlast),
        .phase_rdy  (),
        .diff_dat   (diff_dat),
        .diff_vld   (diff_vld),
        .diff_last  (diff_last),
        .diff_rdy   (in_rdy)
    );

    // diff_vld already excludes clear, so a beat under clear is dropped here too.
    assign beat         = diff_vld & in_rdy;
    // k is only sampled at the start of a window; mid-window changes wait.
    assign k_cur        = (count_q == '0) ? clamp_log2(log2_decim) : k_q;
    assign win_last_cnt = ((CNT_W+1)'(1) << k_cur) - (CNT_W+1)'(1);
    assign window_end   = ({1'b0, count_q} == win_last_cnt);
    assign acc_sum      = acc_q + {{MAX_LOG2_DECIM{diff_dat[WIDTH-1]}}, diff_dat};
    // Round half up: add 2^(k-1), which is zero when k == 0.
    assign half         = ((ACC_WIDTH+1)'(1) << k_cur) >> 1;
    assign rnd_sum      = $signed({acc_sum[ACC_WIDTH-1], acc_sum} + half);
    assign shifted      = rnd_sum >>> k_cur;

    // Saturate the scaled sum into WIDTH bits.
    always_comb begin
        freq = shifted[WIDTH-1:0];
        if (!((&shifted[ACC_WIDTH:WIDTH-1]) || ~(|shifted[ACC_WIDTH:WIDTH-1]))) begin
            freq = shifted[ACC_WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Integrate-and-dump window and output register next state.
    always_comb begin
        acc_d    = acc_q;
        count_d  = count_q;
        k_d      = k_q;
        o_vld_d  = o_vld_q;
        o_dat_d  = o_dat_q;
        o_last_d = o_last_q;
        if (clear) begin
            acc_d    = '0;
            count_d  = '0;
            k_d      = '0;
            o_vld_d  = 1'b0;
            o_dat_d  = '0;
            o_last_d = 1'b0;
        end else begin
            if (o_vld_q && m_out.tready) begin
                o_vld_d = 1'b0;
            end
            if (beat) begin
                k_d = k_cur;
                if (window_end || diff_last) begin
                    acc_d    = '0;
                    count_d  = '0;
                    o_vld_d  = 1'b1;
                    o_dat_d  = freq;
                    o_last_d = diff_last;
                end else begin
                    acc_d   = acc_sum;
                    count_d = count_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            count_q  <= '0;
            k_q      <= '0;
            o_vld_q  <= 1'b0;
            o_dat_q  <= '0;
            o_last_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            count_q  <= count_d;
            k_q      <= k_d;
            o_vld_q  <= o_vld_d;
            o_dat_q  <= o_dat_d;
            o_last_q <= o_last_d;
        end
    end

endmodule

// File: tb/tb_axi_phase_discriminator.sv
// Bench for the FM phase discriminator: directed steps followed by randomized traffic.
// A window-level reference model predicts every output word.
// Outputs are sampled on the falling edge, inputs change just after the rising edge.
module tb_axi_phase_discriminator;
    import axi_phase_discriminator_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [3:0] log2_decim;

    axi_phase_discriminator_if in_if();
    axi_phase_discriminator_if out_if();

    axi_phase_discriminator dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .log2_decim (log2_decim),
        .s_in       (in_if),
        .m_out      (out_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;

    // Reference model: previous phase, current window contents, expected words.
    int          m_prev;
    bit          m_prev_vld;
    int          win_sum;
    int          win_n;
    int          win_k;
    logic [32:0] exp_q[$];
    logic [31:0] got_q[$];

    logic [15:0] t1_exp [4] = '{16'h0000, 16'h0100, 16'h0200, 16'hFF00};
    logic [15:0] t1_ph  [4] = '{16'h0000, 16'h0100, 16'h0300, 16'h0200};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        m_prev_vld = 1'b0;
        m_prev     = 0;
        win_sum    = 0;
        win_n      = 0;
        win_k      = 0;
        exp_q.delete();
    endtask

    task automatic model_beat(input int ph, input bit last);
        int d, div, num, q;
        d = 0;
        if (m_prev_vld) begin
            d = ph - m_prev;
            if (d > 32767) d -= 65536;
            else if (d < -32768) d += 65536;
        end
        m_prev     = ph;
        m_prev_vld = 1'b1;
        if (win_n == 0) win_k = (int'(log2_decim) > 8) ? 8 : int'(log2_decim);
        win_sum += d;
        win_n++;
        if (win_n == (1 << win_k) || last) begin
            div = 1 << win_k;
            num = win_sum + ((win_k > 0) ? div / 2 : 0);
            q   = num / div;
            if ((num % div) != 0 && num < 0) q--;
            if (q > 32767) q = 32767;
            if (q < -32768) q = -32768;
            exp_q.push_back({last, q[15:0], 16'h0000});
            win_sum = 0;
            win_n   = 0;
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model, return after the rising edge.
    task automatic tick();
        logic        exp_rdy;
        logic [32:0] e;
        @(negedge clk);
        exp_rdy = ~out_if.tvalid | out_if.tready;
        check("i_tready_rule", {31'b0, in_if.tready}, {31'b0, exp_rdy});
        if (out_if.tvalid) begin
            if (exp_q.size() == 0) begin
                check("spurious_o_tvalid", {31'b0, out_if.tvalid}, 32'd0);
            end else begin
                e = exp_q[0];
                check("o_tdata", out_if.tdata, e[31:0]);
                check("o_tlast", {31'b0, out_if.tlast}, {31'b0, e[32]});
                if (out_if.tready) begin
                    void'(exp_q.pop_front());
                    got_q.push_back(out_if.tdata);
                end
            end
        end
        if (reset || clear) begin
            model_flush();
        end else if (in_if.tvalid && in_if.tready) begin
            n_acc++;
            model_beat(int'(in_if.tdata[31:16]), in_if.tlast);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] ph, input logic last);
        in_if.tvalid = 1'b1;
        in_if.tdata  = {ph, 16'($urandom)};
        in_if.tlast  = last;
        tick();
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic drain(input string tag);
        in_if.tvalid  = 1'b0;
        out_if.tready = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || out_if.tvalid); i++) tick();
        check({tag, "_drained"}, exp_q.size(), 32'd0);
        check({tag, "_idle"}, {31'b0, out_if.tvalid}, 32'd0);
    endtask

    initial begin
        int n0;
        reset         = 1'b1;
        clear         = 1'b0;
        log2_decim    = 4'd0;
        in_if.tvalid  = 1'b0;
        in_if.tdata   = '0;
        in_if.tlast   = 1'b0;
        out_if.tready = 1'b1;
        model_flush();
        @(posedge clk);
        #1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        check("rst_o_tvalid", {31'b0, out_if.tvalid}, 32'd0);
        check("rst_o_tdata", out_if.tdata, 32'd0);
        check("rst_o_tlast", {31'b0, out_if.tlast}, 32'd0);
        check("rst_i_tready", {31'b0, in_if.tready}, 32'd1);

        // k=0 basic differences, one output per cycle.
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            in_if.tvalid = 1'b1;
            in_if.tdata  = {t1_ph[i], 16'h0000};
            in_if.tlast  = 1'b0;
            tick();
        end
        in_if.tvalid = 1'b0;
        check("k0_no_bubble", got_q.size(), 32'd3);
        drain("k0");
        for (int i = 0; i < 4; i++) check("k0_word", got_q[i], {t1_exp[i], 16'h0000});

        // Wrap through +/-pi.
        do_clear();
        got_q.delete();
        beat(16'h7F00, 1'b0);
        beat(16'h8100, 1'b0);
        drain("wrap");
        check("wrap_word", got_q[1], 32'h0200_0000);

        // k=2 constant step.
        do_clear();
        got_q.delete();
        log2_decim = 4'd2;
        for (int i = 0; i < 8; i++) beat(16'(i * 16'h0040), 1'b0);
        drain("k2");
        check("k2_count", got_q.size(), 32'd2);
        check("k2_w0", got_q[0], 32'h0030_0000);
        check("k2_w1", got_q[1], 32'h0040_0000);

        // k=3 partial window closed by tlast, then a fresh window at k=0.
        do_clear();
        got_q.delete();
        log2_decim = 4'd3;
        for (int i = 0; i < 5; i++) beat(16'(i * 16'h0010), (i == 4));
        log2_decim = 4'd0;
        beat(16'h0050, 1'b0);
        drain("k3");
        check("k3_count", got_q.size(), 32'd2);
        check("k3_w0", got_q[0], 32'h0008_0000);
        check("k3_next", got_q[1], 32'h0010_0000);

        // Backpressure: stall for 10 cycles with a word pending.
        do_clear();
        got_q.delete();
        n0 = n_acc;
        out_if.tready = 1'b0;
        in_if.tvalid  = 1'b1;
        in_if.tlast   = 1'b0;
        in_if.tdata   = 32'h0500_0000;
        tick();
        in_if.tdata   = 32'h0A00_0000;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_i_tready_low", {31'b0, in_if.tready}, 32'd0);
            tick();
        end
        out_if.tready = 1'b1;
        in_if.tdata   = 32'h0C00_0000;
        tick();
        tick();
        drain("bp");
        check("bp_no_loss", got_q.size(), n_acc - n0);

        // Clear mid-window (with a beat offered) discards it; next sample starts at d=0.
        do_clear();
        got_q.delete();
        log2_decim = 4'd4;
        for (int i = 0; i < 6; i++) beat(16'(16'h0100 + i * 16'h0033), 1'b0);
        clear = 1'b1;
        beat(16'h4444, 1'b0);
        clear = 1'b0;
        log2_decim = 4'd0;
        beat(16'h1234, 1'b0);
        drain("clr");
        check("clr_count", got_q.size(), 32'd1);
        check("clr_first_d0", got_q[0], 32'h0000_0000);

        // Reset mid-window behaves the same way.
        got_q.delete();
        log2_decim = 4'd4;
        for (int i = 0; i < 6; i++) beat(16'(16'h2000 + i * 16'h0101), 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        log2_decim = 4'd0;
        beat(16'h7777, 1'b0);
        drain("rst");
        check("rst_count", got_q.size(), 32'd1);
        check("rst_first_d0", got_q[0], 32'h0000_0000);

        // log2_decim above range clamps to 8 (256-beat window).
        do_clear();
        got_q.delete();
        log2_decim = 4'd12;
        for (int i = 0; i < 256; i++) beat(16'(i * 16'h0010), 1'b0);
        drain("clamp");
        check("clamp_count", got_q.size(), 32'd1);
        check("clamp_word", got_q[0], 32'h0010_0000);

        // Randomized traffic: random phases, tlast, ready, decimation and clears.
        for (int c = 0; c < 1500; c++) begin
            in_if.tvalid  = ($urandom_range(0, 3) != 0);
            in_if.tdata   = $urandom;
            in_if.tlast   = ($urandom_range(0, 9) == 0);
            out_if.tready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) log2_decim = 4'($urandom_range(0, 15));
            clear = ($urandom_range(0, 59) == 0);
            tick();
        end
        clear = 1'b0;
        in_if.tlast = 1'b0;
        drain("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_phase_discriminator.md
Name: axi_phase_discriminator

Overview:
- Consumes the 16-bit phase stream produced by the envelope block's phase output (sc16 word, phase in the upper half).
- Differentiates successive phase samples modulo 2π to give instantaneous frequency (FM discriminator).
- Runs the differences through a power-of-two integrate-and-dump decimator, then re-emits sc16 words for a downstream chdr_framer.
- Lives in the ce_clk domain between split_complex/framer-side logic and the output framer.

Parameters:
WIDTH, 16, phase/frequency sample width.
MAX_LOG2_DECIM, 8, largest supported log2 decimation; accumulator width = WIDTH+MAX_LOG2_DECIM.

Ports:
clk  in  1  compute clock (ce_clk).
reset  in  1  synchronous, active-high reset.
clear  in  1  synchronous flush: same effect as reset on internal state, one cycle.
log2_decim  in  4  requested log2 decimation (0 = no decimation), from a settings register.
i_tdata  in  32  phase in [31:16], two's complement scaled radians (0x8000 = −π); [15:0] ignored.
i_tlast  in  1  end of input packet.
i_tvalid  in  1  input valid.
i_tready  out  1  input ready.
o_tdata  out  32  {freq[15:0], 16'h0000}.
o_tlast  out  1  end of output packet.
o_tvalid  out  1  output valid.
o_tready  in  1  output ready.

Behaviour:
- Clock is clk. Reset is synchronous and active-high, on port reset.
- Reset/clear outputs and state: o_tvalid=0, o_tdata=0, o_tlast=0, accumulator=0, count=0, prev_valid=0, k=0.
- Handshake:
  - i_tready = ~o_tvalid | o_tready.
  - An input beat is accepted when i_tvalid & i_tready.
  - The output register holds data stable while o_tvalid & ~o_tready.
- Difference per accepted beat: d = phase − prev_phase, computed mod 2^WIDTH (natural wrap implements ±π unwrap).
  - If prev_valid=0, d=0.
  - Then prev_phase←phase, prev_valid←1.
  - prev_phase persists across packets; it is cleared only by reset/clear.
- Decimation factor k:
  - Latched from log2_decim only when count==0 (start of a new accumulation window).
  - Values above MAX_LOG2_DECIM clamp to MAX_LOG2_DECIM.
  - Changes mid-window have no effect until the next window.
- Accumulation:
  - acc_next = acc + sign-extended d, width WIDTH+MAX_LOG2_DECIM, no saturation needed.
  - count increments per accepted beat.
- Dump condition (on the accepted beat): count==2^k−1 OR i_tlast=1.
  - Output word: freq = (acc_next + 2^(k−1)) >>> k, arithmetic shift, round half up; no rounding term when k=0. Truncated to WIDTH with saturation to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Partial windows dumped by tlast use the same >>>k scaling; they are not renormalised.
  - o_tlast = i_tlast of the dumping beat.
  - acc←0, count←0.
  - o_tvalid←1 on the cycle after the dumping beat (latency 1).
- Non-dump beats produce no output.
- If o_tready and a new dump coincide in the same cycle, the register reloads: back-to-back throughput is 1 word/cycle at k=0.
- Reset or clear mid-window discards the partial accumulation and any pending output word; no output beat is produced for it.
- clear asserted together with an accepted input beat: clear wins and the beat is dropped.

Decomposition:
- Shared package holds:
  - WIDTH default;
  - MAX_LOG2_DECIM;
  - localparam ACC_WIDTH = WIDTH+MAX_LOG2_DECIM;
  - the sc16 packing constant for the zero low half.
- One natural sub-module: phase_diff_wrap. It is a registered modular differencer holding prev_phase/prev_valid with valid/ready passthrough. The integrate-and-dump and output register live in the top module.

Test Plan:
- k=0, phases 0x0000, 0x0100, 0x0300, 0x0200 -> outputs 0x0000, 0x0100, 0x0200, 0xFF00, one per cycle, no bubbles with o_tready=1.
- Wrap: k=0, phases 0x7F00 then 0x8100 -> second output 0x0200 (not −0xFE00).
- k=2, constant step 0x0040 for 8 beats -> two outputs: 0x0030 (first window includes initial d=0: (0+0x40·3+2)>>>2) and then 0x0040.
- k=3, i_tlast on the 5th beat, steps 0x0010 -> one output (0x40+4)>>>3=0x0008 with o_tlast=1; next window starts count=0.
- Backpressure: o_tready=0 for 10 cycles with output pending -> i_tready=0, o_tdata/o_tlast stable; release -> no beats lost or duplicated.
- Reset/clear mid-window (k=4, after 6 beats) -> no output, next first sample yields d=0. log2_decim=12 -> behaves as k=8.
